// File: rtl/tt_um_jleugeri_ttt_sequencer.sv
// Tick scheduler for the ttt core: feeds queued host events, issues advance, waits for the tick
// to complete and queues the core's timestamped token start/stop events for the host.
module tt_um_jleugeri_ttt_sequencer #(
    parameter int  NUM_PROCESSORS = 10,
    parameter int  NEW_TOKEN_BITS = 4,
    parameter int  FIFO_DEPTH     = 4,
    parameter int  TICK_BITS      = 16,
    localparam int PID_W          = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
    input  logic                      clock_fast,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic [PID_W-1:0]          ev_processor_id,
    input  logic [NEW_TOKEN_BITS-1:0] ev_good_tokens,
    input  logic [NEW_TOKEN_BITS-1:0] ev_bad_tokens,
    output logic [3:0]                core_instruction,
    output logic [PID_W-1:0]          core_processor_id,
    output logic [NEW_TOKEN_BITS-1:0] core_good_tokens,
    output logic [NEW_TOKEN_BITS-1:0] core_bad_tokens,
    input  logic [1:0]                core_stage,
    input  logic                      core_output_valid,
    input  logic [PID_W-1:0]          core_processor_id_out,
    input  logic [1:0]                core_token_startstop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PID_W-1:0]          out_processor_id,
    output logic [1:0]                out_startstop,
    output logic [TICK_BITS-1:0]      out_tick,
    output logic [TICK_BITS-1:0]      tick_count,
    output logic                      busy,
    output logic                      overflow
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            PW      = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

    localparam logic [3:0] INSTR_NOP  = 4'b0000;
    localparam logic [3:0] INSTR_FEED = 4'b0001;
    localparam logic [3:0] INSTR_ADV  = 4'b0010;

    typedef struct packed {
        logic [PID_W-1:0]          pid;
        logic [NEW_TOKEN_BITS-1:0] good;
        logic [NEW_TOKEN_BITS-1:0] bad;
    } in_ent_t;

    typedef struct packed {
        logic [PID_W-1:0]     pid;
        logic [1:0]           ss;
        logic [TICK_BITS-1:0] tick;
    } out_ent_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_ADVANCE,
        S_WAIT_LEAVE,
        S_WAIT_RETURN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PW-1:0]        r_feed_cnt;
    logic [PW-1:0]        w_feed_nxt;
    logic [3:0]           r_instr;
    logic [3:0]           w_instr_nxt;
    in_ent_t              r_core_ev;
    in_ent_t              w_core_ev_nxt;
    logic [TICK_BITS-1:0] r_tick;
    logic                 w_tick_inc;
    logic                 r_busy;
    logic                 r_overflow;

    in_ent_t              r_in_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_in_wp;
    logic [PW-1:0]        r_in_rp;
    logic                 r_ev_ready;
    logic                 w_in_push;
    logic                 w_in_pop;
    logic [PW-1:0]        w_in_occ;
    logic [PW-1:0]        w_in_occ_nxt;
    in_ent_t              w_in_head;

    out_ent_t             r_out_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_out_wp;
    logic [PW-1:0]        r_out_rp;
    logic                 r_out_valid;
    logic                 w_out_full;
    logic                 w_cap;
    logic                 w_out_push;
    logic                 w_out_pop;
    logic                 w_drop;
    logic [PW-1:0]        w_out_occ;
    logic [PW-1:0]        w_out_occ_nxt;
    out_ent_t             w_out_head;
    out_ent_t             w_out_new;

    // Input FIFO: pointers carry one extra bit so full and empty are distinguishable.
    assign w_in_occ     = r_in_wp - r_in_rp;
    assign w_in_push    = ev_valid && r_ev_ready;
    assign w_in_head    = r_in_mem[r_in_rp[AW-1:0]];
    assign w_in_occ_nxt = w_in_occ + PW'(w_in_push) - PW'(w_in_pop);

    always_comb begin
        w_state_nxt   = r_state;
        w_feed_nxt    = r_feed_cnt;
        w_in_pop      = 1'b0;
        w_instr_nxt   = INSTR_NOP;
        w_core_ev_nxt = '0;
        w_tick_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    // The occupancy snapshot bounds this tick; later pushes wait for the next one.
                    if (w_in_occ != '0) begin
                        w_in_pop      = 1'b1;
                        w_instr_nxt   = INSTR_FEED;
                        w_core_ev_nxt = w_in_head;
                        w_feed_nxt    = w_in_occ - PW'(1);
                        w_state_nxt   = S_FEED;
                    end else begin
                        w_instr_nxt = INSTR_ADV;
                        w_state_nxt = S_ADVANCE;
                    end
                end
            end
            S_FEED: begin
                if (r_feed_cnt != '0) begin
                    w_in_pop      = 1'b1;
                    w_instr_nxt   = INSTR_FEED;
                    w_core_ev_nxt = w_in_head;
                    w_feed_nxt    = r_feed_cnt - PW'(1);
                end else begin
                    w_instr_nxt = INSTR_ADV;
                    w_state_nxt = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                w_state_nxt = S_WAIT_LEAVE;
            end
            S_WAIT_LEAVE: begin
                if (core_stage != 2'b00) begin
                    w_state_nxt = S_WAIT_RETURN;
                end
            end
            S_WAIT_RETURN: begin
                if (core_stage == 2'b00) begin
                    w_tick_inc  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_fast or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_feed_cnt <= '0;
            r_instr    <= INSTR_NOP;
            r_core_ev  <= '0;
            r_tick     <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_feed_cnt <= w_feed_nxt;
            r_instr    <= w_instr_nxt;
            r_core_ev  <= w_core_ev_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_tick_inc) begin
                r_tick <= r_tick + TICK_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock_fast or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_in_mem[i] <= '0;
            end
            r_in_wp    <= '0;
            r_in_rp    <= '0;
            r_ev_ready <= 1'b1;
        end else begin
            if (w_in_push) begin
                r_in_mem[r_in_wp[AW-1:0]] <= '{pid: ev_processor_id, good: ev_good_tokens, bad: ev_bad_tokens};
                r_in_wp                   <= r_in_wp + PW'(1);
            end
            if (w_in_pop) begin
                r_in_rp <= r_in_rp + PW'(1);
            end
            r_ev_ready <= (w_in_occ_nxt != DEPTH_P);
        end
    end

    // Output FIFO: a pop in the same cycle frees the slot, so a capture on a full FIFO still lands.
    assign w_out_occ     = r_out_wp - r_out_rp;
    assign w_out_full    = (w_out_occ == DEPTH_P);
    assign w_out_pop     = r_out_valid && out_ready;
    assign w_cap         = (r_state == S_WAIT_RETURN) && core_output_valid &&
                           ((core_token_startstop == 2'b10) || (core_token_startstop == 2'b01));
    assign w_out_push    = w_cap && (!w_out_full || w_out_pop);
    assign w_drop        = w_cap && w_out_full && !w_out_pop;
    assign w_out_occ_nxt = w_out_occ + PW'(w_out_push) - PW'(w_out_pop);
    assign w_out_head    = r_out_mem[r_out_rp[AW-1:0]];
    assign w_out_new     = '{pid: core_processor_id_out, ss: core_token_startstop, tick: r_tick};

    always_ff @(posedge clock_fast or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_out_mem[i] <= '0;
            end
            r_out_wp    <= '0;
            r_out_rp    <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_out_push) begin
                r_out_mem[r_out_wp[AW-1:0]] <= w_out_new;
                r_out_wp                    <= r_out_wp + PW'(1);
            end
            if (w_out_pop) begin
                r_out_rp <= r_out_rp + PW'(1);
            end
            r_out_valid <= (w_out_occ_nxt != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ev_ready          = r_ev_ready;
    assign core_instruction  = r_instr;
    assign core_processor_id = r_core_ev.pid;
    assign core_good_tokens  = r_core_ev.good;
    assign core_bad_tokens   = r_core_ev.bad;
    assign out_valid         = r_out_valid;
    assign out_processor_id  = w_out_head.pid;
    assign out_startstop     = w_out_head.ss;
    assign out_tick          = w_out_head.tick;
    assign tick_count        = r_tick;
    assign busy              = r_busy;
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_sequencer.sv
// Bench for the tick sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_tt_um_jleugeri_ttt_sequencer;

    localparam int NP = 10;
    localparam int NT = 4;
    localparam int D  = 4;
    localparam int TB = 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          ev_valid;
    logic          ev_ready;
    logic [3:0]    ev_pid;
    logic [NT-1:0] ev_good;
    logic [NT-1:0] ev_bad;
    logic [3:0]    core_instruction;
    logic [3:0]    core_pid;
    logic [NT-1:0] core_good;
    logic [NT-1:0] core_bad;
    logic [1:0]    core_stage;
    logic          core_ov;
    logic [3:0]    core_pid_out;
    logic [1:0]    core_ss;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_pid;
    logic [1:0]    out_ss;
    logic [TB-1:0] out_tick;
    logic [TB-1:0] tick_count;
    logic          busy;
    logic          overflow;

    tt_um_jleugeri_ttt_sequencer #(
        .NUM_PROCESSORS(NP), .NEW_TOKEN_BITS(NT), .FIFO_DEPTH(D), .TICK_BITS(TB)
    ) dut (
        .clock_fast(clk), .reset_n(rst_n), .enable(enable),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_processor_id(ev_pid),
        .ev_good_tokens(ev_good), .ev_bad_tokens(ev_bad),
        .core_instruction(core_instruction), .core_processor_id(core_pid),
        .core_good_tokens(core_good), .core_bad_tokens(core_bad),
        .core_stage(core_stage), .core_output_valid(core_ov),
        .core_processor_id_out(core_pid_out), .core_token_startstop(core_ss),
        .out_valid(out_valid), .out_ready(out_ready), .out_processor_id(out_pid),
        .out_startstop(out_ss), .out_tick(out_tick), .tick_count(tick_count),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pid;
        logic [3:0] good;
        logic [3:0] bad;
    } ev_t;

    typedef struct {
        logic [3:0] pid;
        logic [1:0] ss;
        logic [3:0] tick;
    } oe_t;

    int  n_tests = 0;
    int  n_fail  = 0;

    // Model: host-visible queues plus where the current tick stands.
    ev_t in_q[$];
    oe_t out_q[$];
    ev_t m_show;
    int  m_feed_rem;
    bit  m_busy;
    bit  m_adv;
    bit  m_left;
    bit  m_ovf;
    int  m_tick;

    int  stub_len;
    int  stub_rem;
    bit  stub_rand;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_instr();
        if (m_feed_rem > 0) return 4'd1;
        if (m_adv) return 4'd2;
        return 4'd0;
    endfunction

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_feed_rem = 0;
        m_busy     = 0;
        m_adv      = 0;
        m_left     = 0;
        m_ovf      = 0;
        m_tick     = 0;
        stub_rem   = 0;
        core_stage = 2'b00;
    endtask

    task automatic model_edge();
        bit  waiting_ret;
        bit  pop_out;
        bit  push_in;
        ev_t e;
        oe_t o;
        waiting_ret = m_busy && (m_feed_rem == 0) && !m_adv && m_left;
        pop_out     = (out_q.size() > 0) && out_ready;
        push_in     = ev_valid && (in_q.size() < D);
        if (pop_out) void'(out_q.pop_front());
        if (waiting_ret && core_ov && (core_ss == 2'b01 || core_ss == 2'b10)) begin
            if (out_q.size() < D) begin
                o.pid = core_pid_out; o.ss = core_ss; o.tick = 4'(m_tick);
                out_q.push_back(o);
            end else begin
                m_ovf = 1;
            end
        end
        if (!m_busy) begin
            if (enable) begin
                m_busy = 1;
                m_left = 0;
                m_feed_rem = in_q.size();
                if (m_feed_rem > 0) m_show = in_q.pop_front();
                else m_adv = 1;
            end
        end else if (m_feed_rem > 0) begin
            m_feed_rem--;
            if (m_feed_rem > 0) m_show = in_q.pop_front();
            else m_adv = 1;
        end else if (m_adv) begin
            m_adv = 0;
        end else if (!m_left) begin
            if (core_stage != 2'b00) m_left = 1;
        end else if (core_stage == 2'b00) begin
            m_tick = (m_tick + 1) % (1 << TB);
            m_busy = 0;
        end
        if (push_in) begin
            e.pid = ev_pid; e.good = ev_good; e.bad = ev_bad;
            in_q.push_back(e);
        end
    endtask

    task automatic compare();
        logic [3:0] ei;
        ei = m_instr();
        chk("instr", core_instruction, ei);
        if (ei == 4'd1) begin
            chk("core_pid", core_pid, m_show.pid);
            chk("core_good", core_good, m_show.good);
            chk("core_bad", core_bad, m_show.bad);
        end
        chk("ev_ready", ev_ready, (in_q.size() < D));
        chk("busy", busy, m_busy);
        chk("tick_count", tick_count, m_tick);
        chk("out_valid", out_valid, (out_q.size() > 0));
        chk("overflow", overflow, m_ovf);
        if (out_q.size() > 0) begin
            chk("out_pid", out_pid, out_q[0].pid);
            chk("out_ss", out_ss, out_q[0].ss);
            chk("out_tick", out_tick, out_q[0].tick);
        end
    endtask

    // One clock: update the model with the inputs just sampled, run the core stub, then compare.
    task automatic step();
        logic [3:0] prev;
        prev = m_instr();
        @(posedge clk);
        #1;
        model_edge();
        if (prev == 4'd2) stub_rem = stub_len;
        if (stub_rem > 0) begin
            core_stage = 2'((stub_rem % 3) + 1);
            stub_rem--;
        end else begin
            core_stage = 2'b00;
        end
        if (stub_rand) begin
            core_ov      = 1'($urandom_range(0, 1));
            core_pid_out = 4'($urandom_range(0, NP - 1));
            core_ss      = 2'($urandom_range(0, 3));
        end
        compare();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 200) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_ev(input logic [3:0] p, input logic [3:0] g, input logic [3:0] b);
        ev_valid = 1'b1; ev_pid = p; ev_good = g; ev_bad = b;
        step();
        ev_valid = 1'b0;
    endtask

    logic [3:0] cap_pid [5];
    logic [1:0] cap_ss  [5];

    initial begin
        rst_n = 1'b0; enable = 1'b0; ev_valid = 1'b0; ev_pid = '0; ev_good = '0; ev_bad = '0;
        core_stage = 2'b00; core_ov = 1'b0; core_pid_out = '0; core_ss = 2'b00; out_ready = 1'b0;
        stub_len = 3; stub_rem = 0; stub_rand = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", core_instruction, 0);
        chk("rst_ev_ready", ev_ready, 1);
        chk("rst_tick", tick_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Capture during tick 0 with the host stalled: five events into a four-deep FIFO.
        cap_pid = '{4'd4, 4'd7, 4'd1, 4'd9, 4'd3};
        cap_ss  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        stub_len = 12;
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            core_ov = 1'b1; core_pid_out = cap_pid[i]; core_ss = cap_ss[i];
            step();
        end
        core_ov = 1'b0;
        wait_idle();
        chk("ovf_set", overflow, 1);
        chk("ovf_head_pid", out_pid, 4);
        chk("ovf_head_ss", out_ss, 2);
        chk("ovf_head_tick", out_tick, 0);
        chk("tick_after_first", tick_count, 1);
        out_ready = 1'b1;
        step();
        chk("second_pid", out_pid, 7);
        chk("second_ss", out_ss, 1);
        repeat (3) step();
        chk("drained", out_valid, 0);
        out_ready = 1'b0;

        // Two queued events fed in order, then advance.
        push_ev(4'd2, 4'd3, 4'd0);
        push_ev(4'd5, 4'hF, 4'd2);
        stub_len = 4;
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("feed1_instr", core_instruction, 1);
        chk("feed1_pid", core_pid, 2);
        chk("feed1_good", core_good, 3);
        chk("feed1_bad", core_bad, 0);
        step();
        chk("feed2_pid", core_pid, 5);
        chk("feed2_good", core_good, 15);
        chk("feed2_bad", core_bad, 2);
        step();
        chk("adv_instr", core_instruction, 2);
        step();
        chk("wait_instr", core_instruction, 0);
        wait_idle();
        chk("tick_two", tick_count, 2);

        // Empty FIFO, core away for 7 cycles.
        stub_len = 7;
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("empty_adv", core_instruction, 2);
        repeat (8) step();
        chk("empty_still_busy", busy, 1);
        chk("empty_tick_old", tick_count, 2);
        step();
        chk("empty_idle", busy, 0);
        chk("empty_tick_new", tick_count, 3);

        // Fill the input FIFO, then push during the first feed cycle.
        stub_len = 2;
        for (int i = 0; i < 4; i++) begin
            push_ev(4'(i + 1), 4'(i), 4'(3 - i));
            chk("fill_ready", ev_ready, (i < 3));
        end
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("fill_feed_pid", core_pid, 1);
        push_ev(4'd9, 4'd6, 4'd1);
        repeat (3) step();
        chk("late_not_fed", core_instruction, 2);
        wait_idle();
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("late_feed_pid", core_pid, 9);
        step();
        chk("late_then_adv", core_instruction, 2);
        wait_idle();
        chk("tick_five", tick_count, 5);

        // Tick counter wraps at 2^TB; overflow stays sticky.
        for (int t = 0; t < 20 && m_tick != 0; t++) begin
            enable = 1'b1;
            step();
            enable = 1'b0;
            wait_idle();
        end
        chk("wrap_tick", tick_count, 0);
        chk("wrap_ovf", overflow, 1);

        // Randomized traffic.
        stub_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            ev_valid  = 1'($urandom_range(0, 1));
            ev_pid    = 4'($urandom_range(0, NP - 1));
            ev_good   = 4'($urandom);
            ev_bad    = 4'($urandom);
            enable    = ($urandom_range(0, 9) < 7);
            out_ready = 1'($urandom_range(0, 1));
            stub_len  = $urandom_range(1, 8);
            step();
        end
        stub_rand = 0;
        core_ov = 1'b0; ev_valid = 1'b0; enable = 1'b0; out_ready = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of feeding.
        do_reset();
        push_ev(4'd1, 4'd1, 4'd1);
        push_ev(4'd2, 4'd2, 4'd2);
        push_ev(4'd3, 4'd3, 4'd3);
        stub_len = 3;
        enable = 1'b1;
        step();
        step();
        chk("mid_feed_instr", core_instruction, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_instr", core_instruction, 0);
        chk("arst_ev_ready", ev_ready, 1);
        chk("arst_tick", tick_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overflow", overflow, 0);
        model_reset();
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
